// File: rtl/pcm_bus_engine.sv
// Bus-cycle engine for a PCM device: device reset sequencing, then one timed
// write, read or status-poll cycle per accepted command, with data-bus direction control.
module pcm_bus_engine #(
    parameter int unsigned WE_PULSE   = 6,
    parameter int unsigned WE_RECOVER = 3,
    parameter int unsigned RD_WAIT    = 13,
    parameter int unsigned POLL_LIMIT = 16'hFFFF,
    parameter int unsigned RST_HOLD   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [22:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [22:0] pcm_addr,
    inout  wire  [15:0] pcm_data,
    output logic        pcm_rst_n,
    output logic        pcm_ce_n,
    output logic        pcm_oe_n,
    output logic        pcm_we_n
);

    typedef enum logic [2:0] {
        S_INIT_RST,
        S_INIT_REC,
        S_IDLE,
        S_WR_PULSE,
        S_WR_REC,
        S_RD_LOW,
        S_RD_HIGH,
        S_DONE
    } state_e;

    localparam logic [1:0]  OP_WRITE = 2'b00;
    localparam logic [1:0]  OP_READ  = 2'b01;
    localparam logic [1:0]  OP_POLL  = 2'b10;

    // Each timed state ends on the cycle its counter reaches the last index.
    localparam logic [15:0] RST_LAST = 16'(RST_HOLD - 1);
    localparam logic [15:0] WP_LAST  = 16'(WE_PULSE - 1);
    localparam logic [15:0] WR_LAST  = 16'(WE_RECOVER - 1);
    localparam logic [15:0] RD_LAST  = 16'(RD_WAIT - 1);
    localparam logic [15:0] POLL_MAX = 16'(POLL_LIMIT);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] poll_q, poll_d;
    logic [1:0]  op_q, op_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rd_q, rd_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        err_q, err_d;
    logic        drive_bus;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        poll_d     = poll_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;

        case (state_q)
            S_INIT_RST: begin
                if (cnt_q == RST_LAST) state_d = S_INIT_REC;
                else                   cnt_d   = cnt_q + 16'd1;
            end
            S_INIT_REC: begin
                if (cnt_q == RST_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + 16'd1;
            end
            S_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    poll_d = '0;
                    err_d  = 1'b0;
                    case (req_op)
                        OP_WRITE: begin
                            state_d = S_WR_PULSE;
                            addr_d  = req_addr;
                            wdata_d = req_wdata;
                        end
                        OP_READ, OP_POLL: begin
                            state_d = S_RD_LOW;
                            addr_d  = req_addr;
                        end
                        default: begin
                            // Reserved op: answer with an error and leave the pins alone.
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_WR_PULSE: begin
                if (cnt_q == WP_LAST) state_d = S_WR_REC;
                else                  cnt_d   = cnt_q + 16'd1;
            end
            S_WR_REC: begin
                if (cnt_q == WR_LAST) state_d = S_DONE;
                else                  cnt_d   = cnt_q + 16'd1;
            end
            S_RD_LOW: begin
                if (cnt_q == RD_LAST) begin
                    state_d = S_RD_HIGH;
                    rd_d    = pcm_data;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RD_HIGH: begin
                if (op_q != OP_POLL || rd_q[7]) begin
                    state_d    = S_DONE;
                    rsp_data_d = rd_q;
                end else if (poll_q + 16'd1 == POLL_MAX) begin
                    state_d    = S_DONE;
                    rsp_data_d = rd_q;
                    err_d      = 1'b1;
                end else begin
                    state_d = S_RD_LOW;
                    poll_d  = poll_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT_RST;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_INIT_RST;
            cnt_q      <= '0;
            poll_q     <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            poll_q     <= poll_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    // Pins decode straight from the state register, so a reset edge clears them at once.
    assign drive_bus = (state_q == S_WR_PULSE) || (state_q == S_WR_REC);
    assign pcm_data  = drive_bus ? wdata_q : 16'hzzzz;
    assign pcm_addr  = addr_q;
    assign pcm_rst_n = (state_q != S_INIT_RST);
    assign pcm_ce_n  = !((state_q == S_WR_PULSE) || (state_q == S_RD_LOW));
    assign pcm_we_n  = (state_q != S_WR_PULSE);
    assign pcm_oe_n  = (state_q != S_RD_LOW);

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_err   = (state_q == S_DONE) && err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_pcm_bus_engine.sv
// Bench for pcm_bus_engine: directed and random commands checked against a
// cycle-window / response model of the bus rules, with a simple PCM device on the bus.
`timescale 1ns/1ps
module tb_pcm_bus_engine;

    localparam int WP = 6;
    localparam int WR = 3;
    localparam int RD = 13;
    localparam int PL = 4;
    localparam int RH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [22:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [22:0] pcm_addr;
    tri1  [15:0] pcm_data;
    logic        pcm_rst_n;
    logic        pcm_ce_n;
    logic        pcm_oe_n;
    logic        pcm_we_n;

    // Device model: drives its current status/read value while ce_n and oe_n are low.
    logic [15:0] dev_val;
    logic        dev_en;
    assign dev_en   = !pcm_ce_n && !pcm_oe_n;
    assign pcm_data = dev_en ? dev_val : 16'hzzzz;

    logic [15:0] st [PL];
    logic [15:0] m_rsp_data;
    int          n_checks = 0;
    int          n_fail   = 0;

    pcm_bus_engine #(
        .WE_PULSE  (WP),
        .WE_RECOVER(WR),
        .RD_WAIT   (RD),
        .POLL_LIMIT(PL),
        .RST_HOLD  (RH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .pcm_addr (pcm_addr),
        .pcm_data (pcm_data),
        .pcm_rst_n(pcm_rst_n),
        .pcm_ce_n (pcm_ce_n),
        .pcm_oe_n (pcm_oe_n),
        .pcm_we_n (pcm_we_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with rst_n low; that next edge is cycle 0.
    task automatic run_init(input string nm);
        int rst_bad = 0;
        int rdy_bad = 0;
        int pin_bad = 0;
        int rsp_bad = 0;
        rst_n = 1'b1;
        for (int k = 0; k <= 2 * RH + 2; k++) begin
            @(negedge clk); #1;
            if (pcm_rst_n !== (k >= RH)) rst_bad++;
            if (req_ready !== (k >= 2 * RH)) rdy_bad++;
            if ({pcm_ce_n, pcm_oe_n, pcm_we_n} !== 3'b111 || pcm_data !== 16'hFFFF) pin_bad++;
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) rsp_bad++;
        end
        check({nm, "_pcm_rst_n_timing"}, rst_bad, 0);
        check({nm, "_req_ready_timing"}, rdy_bad, 0);
        check({nm, "_pins_quiet"}, pin_bad, 0);
        check({nm, "_no_rsp"}, rsp_bad, 0);
        check({nm, "_rsp_data_cleared"}, rsp_data, 16'h0000);
        m_rsp_data = 16'h0000;
    endtask

    // One command from accept to the cycle after its response, checked against the model.
    task automatic run_cmd(input logic [1:0] op, input logic [22:0] addr, input logic [15:0] wdata);
        string       nm;
        int          n_att, done_at, w, a, off;
        int          rv_at = 0;
        int          rv_cnt = 0;
        int          pin_bad = 0;
        int          bus_bad = 0;
        int          rdy_bad = 0;
        logic        exp_err, e_ce, e_oe, e_we, e_drv, got_err;
        logic [15:0] exp_data, got_data;

        // Expected response from the command rules alone.
        n_att    = 1;
        exp_err  = 1'b0;
        exp_data = m_rsp_data;
        got_err  = 1'bx;
        got_data = 16'hxxxx;
        case (op)
            2'b00: begin nm = "write"; done_at = 1 + WP + WR; end
            2'b01: begin nm = "read"; done_at = RD + 2; exp_data = st[0]; end
            2'b10: begin
                nm = "poll";
                while (n_att < PL && !st[n_att-1][7]) n_att++;
                exp_data = st[n_att-1];
                exp_err  = !exp_data[7];
                done_at  = RD + 2 + (RD + 1) * (n_att - 1);
            end
            default: begin nm = "reserved"; done_at = 1; exp_err = 1'b1; end
        endcase

        w = 0;
        while (req_ready !== 1'b1 && w < 200) begin
            @(negedge clk); #1;
            w++;
        end
        check({nm, "_ready_before_accept"}, req_ready, 1'b1);

        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_addr  = 23'($urandom);
        req_wdata = 16'($urandom);

        for (int k = 1; k <= done_at + 1; k++) begin
            @(negedge clk);
            a       = (k - 1) / (RD + 1);
            off     = (k - 1) % (RD + 1);
            dev_val = st[(a < PL) ? a : PL - 1];
            #1;
            e_we  = 1'b1;
            e_oe  = 1'b1;
            e_drv = 1'b0;
            if (op == 2'b00) begin
                e_we  = !(k <= WP);
                e_drv = (k <= WP + WR);
            end else if (op == 2'b01 || op == 2'b10) begin
                e_oe = !(a < n_att && off < RD);
            end
            e_ce = e_we && e_oe;
            if ({pcm_ce_n, pcm_oe_n, pcm_we_n} !== {e_ce, e_oe, e_we}) pin_bad++;
            if (e_drv) begin
                if (pcm_data !== wdata) bus_bad++;
            end else if (!e_oe) begin
                if (pcm_data !== dev_val) bus_bad++;
            end else if (pcm_data !== 16'hFFFF) begin
                bus_bad++;
            end
            if (!e_ce && pcm_addr !== addr) bus_bad++;
            if (rsp_valid === 1'b1) begin
                rv_cnt++;
                if (rv_at == 0) begin
                    rv_at    = k;
                    got_data = rsp_data;
                    got_err  = rsp_err;
                end
            end
            if (req_ready !== (k > done_at)) rdy_bad++;
        end

        check({nm, "_rsp_cycle"}, rv_at, done_at);
        check({nm, "_rsp_pulse_count"}, rv_cnt, 1);
        check({nm, "_rsp_data"}, got_data, exp_data);
        check({nm, "_rsp_err"}, got_err, exp_err);
        check({nm, "_ctrl_pins"}, pin_bad, 0);
        check({nm, "_bus_addr_data"}, bus_bad, 0);
        check({nm, "_req_ready"}, rdy_bad, 0);
        m_rsp_data = exp_data;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_addr   = '0;
        req_wdata  = '0;
        dev_val    = '0;
        m_rsp_data = '0;
        for (int i = 0; i < PL; i++) st[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_pcm_rst_n", pcm_rst_n, 1'b0);
        check("reset_ctrl_pins", {pcm_ce_n, pcm_oe_n, pcm_we_n}, 3'b111);
        check("reset_pcm_addr", pcm_addr, 23'h0);
        check("reset_pcm_data_z", pcm_data, 16'hFFFF);
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data", rsp_data, 16'h0000);
        check("reset_rsp_err", rsp_err, 1'b0);

        run_init("init");

        run_cmd(2'b00, 23'h111100, 16'h00EA);
        st[0] = 16'h1234;
        run_cmd(2'b01, 23'h111105, 16'h0000);
        st[0] = 16'h0000; st[1] = 16'h0000; st[2] = 16'h0080; st[3] = 16'h0000;
        run_cmd(2'b10, 23'h000000, 16'h0000);
        for (int i = 0; i < PL; i++) st[i] = 16'h0000;
        run_cmd(2'b10, 23'h000010, 16'h0000);
        run_cmd(2'b11, 23'h7FFFFF, 16'hFFFF);
        run_cmd(2'b00, 23'h000001, 16'hFFFF);

        // Reset asserted at cycle 4 of a write: pins release at that edge, command dropped.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 23'h0ABCDE;
        req_wdata = 16'h5A5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
        end
        check("midrst_we_low_before", pcm_we_n, 1'b0);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("midrst_ctrl_pins", {pcm_ce_n, pcm_oe_n, pcm_we_n}, 3'b111);
        check("midrst_pcm_data_z", pcm_data, 16'hFFFF);
        check("midrst_pcm_rst_n", pcm_rst_n, 1'b0);
        check("midrst_pcm_addr", pcm_addr, 23'h0);
        check("midrst_no_rsp", rsp_valid, 1'b0);
        check("midrst_req_ready", req_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        run_init("reinit");

        repeat (40) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            for (int i = 0; i < PL; i++) begin
                st[i] = 16'($urandom);
                if ($urandom_range(0, 2) != 0) st[i][7] = 1'b0;
            end
            run_cmd(op, 23'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
